control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/step_counter.sv | 41 ++++
 rtl/control_sequencer.sv | 137 +++++++++++++
 tb/tb_control_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, control-word bit
// positions, step width and the per-opcode final-step lookup.
package cpu_pkg;

  localparam int STEP_W = 3;
  localparam int CTRL_W = 16;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_e;

  // Index of the last active microstep for an opcode (fetch included).
  function automatic logic [STEP_W-1:0] op_last_step(input logic [3:0] op);
    logic [STEP_W-1:0] last;
    case (op)
      OP_LDA, OP_STA: last = STEP_W'(3);
      OP_ADD, OP_SUB: last = STEP_W'(4);
      default:        last = STEP_W'(2);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Microstep counter: counts up each clock, returns to 0 on wrap_i or after
// LAST_STEP, and holds its value while hold_i is high.
module step_counter
  import cpu_pkg::*;
#(
  parameter int LAST_STEP = 4
) (
  input  logic              clk_i,
  input  logic              clr_n_i,
  input  logic              wrap_i,
  input  logic              hold_i,
  output logic [STEP_W-1:0] step_o
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(LAST_STEP);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  always_comb begin
    step_d = step_q;
    if (hold_i) begin
      step_d = step_q;
    end else if (wrap_i || (step_q == LAST)) begin
      step_d = '0;
    end else begin
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: decodes step/opcode/flags into the 16-bit
// control word. JC/JZ are conditional only when CTRL_COND_JUMP_EN is defined.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int LAST_STEP = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [7:0]  ir,
  input  logic        cf,
  input  logic        zf,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  seq_state_e state_q;
  seq_state_e state_d;

  logic [3:0]        opcode;
  logic [STEP_W-1:0] step_w;
  logic              wrap;
  logic              hold;
  logic              jc_take;
  logic              jz_take;
  logic              unused_inputs;

  assign opcode = ir[7:4];

`ifdef CTRL_COND_JUMP_EN
  assign jc_take       = cf;
  assign jz_take       = zf;
  assign unused_inputs = ^ir[3:0];
`else
  assign jc_take       = 1'b0;
  assign jz_take       = 1'b0;
  assign unused_inputs = ^{ir[3:0], cf, zf};
`endif

  step_counter #(
    .LAST_STEP(LAST_STEP)
  ) u_step_counter (
    .clk_i  (clk),
    .clr_n_i(clr_n),
    .wrap_i (wrap),
    .hold_i (hold),
    .step_o (step_w)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= SEQ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode is only trusted from step 2, so wrap/halt decisions never look at ir earlier.
  always_comb begin
    ctrl    = '0;
    wrap    = 1'b0;
    hold    = 1'b0;
    state_d = state_q;

    if (state_q == SEQ_HALT) begin
      ctrl[B_HLT] = 1'b1;
      hold        = 1'b1;
    end else begin
      case (step_w)
        3'd0: begin
          ctrl[B_CO] = 1'b1;
          ctrl[B_MI] = 1'b1;
        end
        3'd1: begin
          ctrl[B_RO] = 1'b1;
          ctrl[B_II] = 1'b1;
          ctrl[B_CE] = 1'b1;
        end
        default: begin
          wrap = (step_w == op_last_step(opcode)) && (opcode != OP_HLT);
          case (opcode)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
              if (step_w == 3'd2) begin
                ctrl[B_IO] = 1'b1;
                ctrl[B_MI] = 1'b1;
              end else if (step_w == 3'd3) begin
                ctrl[B_RO] = (opcode != OP_STA);
                ctrl[B_AO] = (opcode == OP_STA);
                ctrl[B_RI] = (opcode == OP_STA);
                ctrl[B_AI] = (opcode == OP_LDA);
                ctrl[B_BI] = (opcode == OP_ADD) || (opcode == OP_SUB);
              end else if ((step_w == 3'd4) && ((opcode == OP_ADD) || (opcode == OP_SUB))) begin
                ctrl[B_EO] = 1'b1;
                ctrl[B_AI] = 1'b1;
                ctrl[B_FI] = 1'b1;
                ctrl[B_SU] = (opcode == OP_SUB);
              end
            end
            OP_LDI: begin
              ctrl[B_IO] = (step_w == 3'd2);
              ctrl[B_AI] = (step_w == 3'd2);
            end
            OP_JMP: begin
              ctrl[B_IO] = (step_w == 3'd2);
              ctrl[B_J]  = (step_w == 3'd2);
            end
            OP_JC: begin
              ctrl[B_IO] = (step_w == 3'd2) && jc_take;
              ctrl[B_J]  = (step_w == 3'd2) && jc_take;
            end
            OP_JZ: begin
              ctrl[B_IO] = (step_w == 3'd2) && jz_take;
              ctrl[B_J]  = (step_w == 3'd2) && jz_take;
            end
            OP_OUT: begin
              ctrl[B_AO] = (step_w == 3'd2);
              ctrl[B_OI] = (step_w == 3'd2);
            end
            OP_HLT: begin
              if (step_w == 3'd2) begin
                ctrl[B_HLT] = 1'b1;
                hold        = 1'b1;
                state_d     = SEQ_HALT;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign step   = step_w;
  assign halted = (state_q == SEQ_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: the driver pushes the expected
// {halted, step, ctrl} for every cycle, the negedge monitor pops and compares.
module tb_control_sequencer;

  logic        clk;
  logic        clr_n;
  logic [7:0]  ir;
  logic        cf;
  logic        zf;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  logic [19:0] exp_q[$];
  int          total;
  int          bad;

`ifdef CTRL_COND_JUMP_EN
  localparam logic [15:0] JMP_TAKEN = 16'h0802;
`else
  localparam logic [15:0] JMP_TAKEN = 16'h0000;
`endif

  control_sequencer #(
    .LAST_STEP(4)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .ir    (ir),
    .cf    (cf),
    .zf    (zf),
    .ctrl  (ctrl),
    .step  (step),
    .halted(halted)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [19:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total = total + 1;
      if ({halted, step, ctrl} !== e) begin
        bad = bad + 1;
        $display("FAIL cycle_check t=%0t: got ctrl=%h step=%0d halted=%b, want ctrl=%h step=%0d halted=%b",
                 $time, ctrl, step, halted, e[15:0], e[18:16], e[19]);
      end
    end
  end

  // Drive inputs for the current cycle, record its expectation, advance.
  task automatic cyc(input logic [7:0] ir_v, input logic cf_v, input logic zf_v,
                     input logic [15:0] c, input logic [2:0] s, input logic h);
    ir = ir_v;
    cf = cf_v;
    zf = zf_v;
    exp_q.push_back({h, s, c});
    @(posedge clk);
    #1;
  endtask

  // One full instruction; fetch runs with fir on ir to show it is ignored.
  task automatic instr(input logic [7:0] fir, input logic [7:0] ir_v,
                       input logic cf_v, input logic zf_v, input int len,
                       input logic [15:0] e2, input logic [15:0] e3,
                       input logic [15:0] e4);
    cyc(fir, cf_v, zf_v, 16'h4004, 3'd0, 1'b0);
    cyc(fir, cf_v, zf_v, 16'h1408, 3'd1, 1'b0);
    cyc(ir_v, cf_v, zf_v, e2, 3'd2, 1'b0);
    if (len > 3) cyc(ir_v, cf_v, zf_v, e3, 3'd3, 1'b0);
    if (len > 4) cyc(ir_v, cf_v, zf_v, e4, 3'd4, 1'b0);
  endtask

  // Stimulus
  initial begin
    total = 0;
    bad   = 0;
    clr_n = 1'b1;
    ir    = 8'h2E;
    cf    = 1'b0;
    zf    = 1'b0;
    #2 clr_n = 1'b0;
    @(posedge clk);
    #1;
    cyc(8'h2E, 1'b0, 1'b0, 16'h4004, 3'd0, 1'b0);
    cyc(8'hF0, 1'b1, 1'b1, 16'h4004, 3'd0, 1'b0);
    clr_n = 1'b1;

    // NOP run: wraps after three cycles
    cyc(8'h00, 1'b0, 1'b0, 16'h4004, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 16'h1408, 3'd1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 16'h4004, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 16'h1408, 3'd1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);

    instr(8'h50, 8'h2E, 1'b0, 1'b0, 5, 16'h4800, 16'h1020, 16'h0281);
    instr(8'hF0, 8'h3E, 1'b0, 1'b0, 5, 16'h4800, 16'h1020, 16'h02C1);
    instr(8'h2E, 8'h1C, 1'b0, 1'b0, 4, 16'h4800, 16'h1200, 16'h0000);
    instr(8'h00, 8'h4C, 1'b0, 1'b0, 4, 16'h4800, 16'h2100, 16'h0000);
    instr(8'h3E, 8'h57, 1'b0, 1'b0, 3, 16'h0A00, 16'h0000, 16'h0000);
    instr(8'h00, 8'h63, 1'b0, 1'b0, 3, 16'h0802, 16'h0000, 16'h0000);
    instr(8'h00, 8'hE0, 1'b0, 1'b0, 3, 16'h0110, 16'h0000, 16'h0000);
    instr(8'h2E, 8'hB5, 1'b1, 1'b1, 3, 16'h0000, 16'h0000, 16'h0000);
    instr(8'h00, 8'h7A, 1'b1, 1'b0, 3, JMP_TAKEN, 16'h0000, 16'h0000);
    instr(8'h00, 8'h7A, 1'b0, 1'b1, 3, 16'h0000, 16'h0000, 16'h0000);
    instr(8'h00, 8'h81, 1'b0, 1'b1, 3, JMP_TAKEN, 16'h0000, 16'h0000);
    instr(8'h00, 8'h81, 1'b1, 1'b0, 3, 16'h0000, 16'h0000, 16'h0000);

    // Reset during ADD step 3, then a clean LDI
    cyc(8'h50, 1'b0, 1'b0, 16'h4004, 3'd0, 1'b0);
    cyc(8'h50, 1'b0, 1'b0, 16'h1408, 3'd1, 1'b0);
    cyc(8'h2E, 1'b0, 1'b0, 16'h4800, 3'd2, 1'b0);
    ir = 8'h2E;
    #1 clr_n = 1'b0;
    exp_q.push_back({1'b0, 3'd0, 16'h4004});
    @(posedge clk);
    #1;
    cyc(8'h2E, 1'b0, 1'b0, 16'h4004, 3'd0, 1'b0);
    clr_n = 1'b1;
    instr(8'h00, 8'h51, 1'b0, 1'b0, 3, 16'h0A00, 16'h0000, 16'h0000);

    // HLT: halts after step 2 and holds regardless of ir
    instr(8'h00, 8'hF0, 1'b0, 1'b0, 3, 16'h8000, 16'h0000, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      cyc((i % 2 == 0) ? 8'h2E : 8'h00, 1'b1, 1'b1, 16'h8000, 3'd2, 1'b1);
    end
    ir = 8'h00;
    #1 clr_n = 1'b0;
    exp_q.push_back({1'b0, 3'd0, 16'h4004});
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    instr(8'h00, 8'h00, 1'b0, 1'b0, 3, 16'h0000, 16'h0000, 16'h0000);
    cyc(8'h00, 1'b0, 1'b0, 16'h4004, 3'd0, 1'b0);

    @(negedge clk);
    #1;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
